// File: rtl/ycc_mcu_stager.sv
// Ping-pong stager: collects one 4:4:4 MCU as serial Y/Cb/Cr blocks and
// re-emits it as co-located (Y, Cb, Cr) triplets for ycc_col_conv.
module ycc_mcu_stager #(
   parameter int DW    = 8,
   parameter int OUT_W = 32,
   parameter int BLK   = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_y,
   output logic [OUT_W-1:0] out_cb,
   output logic [OUT_W-1:0] out_cr,
   output logic             out_first,
   output logic             out_last,
   output logic             mcu_done
);

   localparam int RCW = $clog2(BLK);
   localparam int WCW = RCW + 2;

   typedef enum logic [1:0] {W_Y = 2'd0, W_CB = 2'd1, W_CR = 2'd2} wr_state_t;
   typedef enum logic {R_IDLE = 1'b0, R_STREAM = 1'b1} rd_state_t;

   logic [DW-1:0]  r_mem [2][3][BLK];
   logic           r_wr_bank, r_rd_bank, r_mcu_done;
   logic [1:0]     r_full;
   logic [WCW-1:0] r_wr_cnt;
   logic [RCW-1:0] r_rd_cnt;

   logic           w_wr_bank_nx, w_rd_bank_nx;
   logic [1:0]     w_full_nx;
   logic [WCW-1:0] w_wr_cnt_nx;
   logic [RCW-1:0] w_rd_cnt_nx;
   logic           w_wr_fire, w_wr_wrap, w_rd_fire, w_rd_wrap;
   wr_state_t      w_wr_state;
   rd_state_t      w_rd_state;
   logic [RCW-1:0] w_wr_off;

   // The write counter's upper bits name the component block being filled.
   assign w_wr_state = wr_state_t'(r_wr_cnt[WCW-1:RCW]);
   assign w_wr_off   = r_wr_cnt[RCW-1:0];
   assign w_rd_state = r_full[r_rd_bank] ? R_STREAM : R_IDLE;

   assign in_ready  = !r_full[r_wr_bank];
   assign w_wr_fire = in_valid && in_ready;
   assign w_wr_wrap = w_wr_fire && (r_wr_cnt == WCW'(3*BLK-1));

   assign out_valid = (w_rd_state == R_STREAM);
   assign w_rd_fire = out_valid && out_ready;
   assign w_rd_wrap = w_rd_fire && (r_rd_cnt == RCW'(BLK-1));

   assign out_y     = OUT_W'(r_mem[r_rd_bank][W_Y][r_rd_cnt]);
   assign out_cb    = OUT_W'(r_mem[r_rd_bank][W_CB][r_rd_cnt]);
   assign out_cr    = OUT_W'(r_mem[r_rd_bank][W_CR][r_rd_cnt]);
   assign out_first = out_valid && (r_rd_cnt == '0);
   assign out_last  = out_valid && (r_rd_cnt == RCW'(BLK-1));
   assign mcu_done  = r_mcu_done;

   // NOTE: every signal gets a default before any branch, so no latch can be inferred.
   always_comb begin
      w_wr_cnt_nx  = r_wr_cnt;
      w_wr_bank_nx = r_wr_bank;
      w_rd_cnt_nx  = r_rd_cnt;
      w_rd_bank_nx = r_rd_bank;
      w_full_nx    = r_full;
      if (w_wr_fire) w_wr_cnt_nx = w_wr_wrap ? '0 : r_wr_cnt + 1'b1;
      if (w_wr_wrap) begin
         w_full_nx[r_wr_bank] = 1'b1;
         w_wr_bank_nx         = ~r_wr_bank;
      end
      // Write and read completions only coincide on different banks, so both flag updates stand.
      if (w_rd_fire) w_rd_cnt_nx = r_rd_cnt + 1'b1;
      if (w_rd_wrap) begin
         w_full_nx[r_rd_bank] = 1'b0;
         w_rd_bank_nx         = ~r_rd_bank;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_bank  <= 1'b0;
         r_rd_bank  <= 1'b0;
         r_full     <= 2'b00;
         r_wr_cnt   <= '0;
         r_rd_cnt   <= '0;
         r_mcu_done <= 1'b0;
      end else begin
         r_wr_bank  <= w_wr_bank_nx;
         r_rd_bank  <= w_rd_bank_nx;
         r_full     <= w_full_nx;
         r_wr_cnt   <= w_wr_cnt_nx;
         r_rd_cnt   <= w_rd_cnt_nx;
         r_mcu_done <= w_rd_wrap;
      end
   end

   // NOTE: sample storage is deliberately not reset; the full flags guard every read.
   always_ff @(posedge clk) begin
      if (w_wr_fire) r_mem[r_wr_bank][w_wr_state][w_wr_off] <= in_data;
   end

endmodule

// File: tb/tb_ycc_mcu_stager.sv
// Randomized self-checking bench for ycc_mcu_stager against a queue-based MCU model.
module tb_ycc_mcu_stager;

   localparam int DW = 8, OUT_W = 32, BLK = 64, N = 3*BLK;

   typedef struct packed {logic [7:0] y; logic [7:0] cb; logic [7:0] cr;} trip_t;
   typedef struct packed {logic [31:0] y; logic [31:0] cb; logic [31:0] cr; logic first; logic last;} obs_t;

   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic in_ready, out_valid, out_first, out_last, mcu_done;
   logic [OUT_W-1:0] out_y, out_cb, out_cr;

   int n_checks = 0, n_fail = 0, n_done = 0;
   logic [7:0] m_buf[$];
   trip_t      exp_q[$];
   logic [7:0] mcu [N];

   ycc_mcu_stager #(.DW(DW), .OUT_W(OUT_W), .BLK(BLK)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_cb(out_cb),
      .out_cr(out_cr), .out_first(out_first), .out_last(out_last), .mcu_done(mcu_done));

   always #5 clk = ~clk;
   always @(negedge clk) if (mcu_done === 1'b1) n_done++;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: a full MCU of 3*BLK accepted samples yields BLK triplets (s[k], s[BLK+k], s[2BLK+k]).
   function automatic void model_accept(logic [7:0] d);
      m_buf.push_back(d);
      if (m_buf.size() == N) begin
         for (int k = 0; k < BLK; k++) exp_q.push_back('{m_buf[k], m_buf[BLK+k], m_buf[2*BLK+k]});
         m_buf.delete();
      end
   endfunction

   function automatic void model_reset();
      m_buf.delete();
      exp_q.delete();
   endfunction

   function automatic obs_t exp_obs(trip_t e, int j);
      return '{32'(e.y), 32'(e.cb), 32'(e.cr), (j == 0), (j == BLK-1)};
   endfunction

   function automatic obs_t cur_obs();
      return '{out_y, out_cb, out_cr, out_first, out_last};
   endfunction

   // All driver tasks start and end 1 time unit after a rising edge; outputs are sampled on falling edges.
   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
   endtask

   task automatic push_sample(input logic [7:0] d, input int pct, output bit ok);
      int n = 0;
      ok = 1'b0;
      in_data = d;
      while (!ok && n < 1000) begin
         in_valid = (int'($urandom_range(0, 99)) < pct);
         @(negedge clk);
         if (in_valid && in_ready === 1'b1) begin
            ok = 1'b1;
            model_accept(d);
         end
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b0;
   endtask

   task automatic send_mcu(input int pct, output bit ok);
      bit o;
      ok = 1'b1;
      for (int i = 0; i < N; i++) begin
         push_sample(mcu[i], pct, o);
         if (!o) begin ok = 1'b0; break; end
      end
   endtask

   task automatic recv_one(input int pct, output obs_t o, output bit ok);
      int n = 0;
      ok = 1'b0;
      o = '0;
      while (!ok && n < 1000) begin
         out_ready = (int'($urandom_range(0, 99)) < pct);
         @(negedge clk);
         if (out_valid === 1'b1 && out_ready) begin
            ok = 1'b1;
            o = cur_obs();
         end
         @(posedge clk); #1;
         n++;
      end
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_checks++; if ({out_first, out_last} !== 2'b00) begin n_fail++; $display("FAIL reset_first_last: got %b want 00", {out_first, out_last}); end
      n_checks++; if (mcu_done !== 1'b0) begin n_fail++; $display("FAIL reset_mcu_done: got %b want 0", mcu_done); end
      @(posedge clk); #1 rst = 1'b0;
      model_reset();
   endtask

   task automatic test_single();
      bit ok;
      int d0;
      obs_t want;
      for (int i = 0; i < BLK; i++) begin
         mcu[i] = 8'(i); mcu[BLK+i] = 8'd128; mcu[2*BLK+i] = 8'(255 - i);
      end
      out_ready = 1'b1;
      send_mcu(100, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL single_send: timeout accepting samples"); end
      d0 = n_done;
      for (int k = 0; k < BLK; k++) begin
         @(negedge clk);
         want = '{32'(k), 32'd128, 32'(255 - k), (k == 0), (k == BLK-1)};
         n_checks++;
         if (out_valid !== 1'b1 || cur_obs() !== want) begin
            n_fail++; $display("FAIL single_pixel k=%0d: valid=%b got %h want %h", k, out_valid, cur_obs(), want);
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_after: got %b want 0", out_valid); end
      n_checks++; if (mcu_done !== 1'b1) begin n_fail++; $display("FAIL single_done_pulse: got %b want 1", mcu_done); end
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++; if (mcu_done !== 1'b0) begin n_fail++; $display("FAIL single_done_width: got %b want 0", mcu_done); end
      @(posedge clk); #1;
      n_checks++; if (n_done - d0 != 1) begin n_fail++; $display("FAIL single_done_count: got %0d want 1", n_done - d0); end
      out_ready = 1'b0;
      model_reset();
   endtask

   task automatic test_stall();
      bit ok;
      obs_t want;
      do_reset();
      send_mcu(100, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_send: timeout accepting samples"); end
      out_ready = 1'b1;
      for (int k = 0; k < BLK; k++) begin
         if (k == 10) begin
            out_ready = 1'b0;
            repeat (5) begin
               @(negedge clk);
               n_checks++;
               if (out_valid !== 1'b1 || out_y !== 32'd10 || out_cr !== 32'd245 || out_cb !== 32'd128) begin
                  n_fail++; $display("FAIL stall_hold: valid=%b y=%0d cb=%0d cr=%0d want 1/10/128/245", out_valid, out_y, out_cb, out_cr);
               end
               @(posedge clk); #1;
            end
            out_ready = 1'b1;
         end
         @(negedge clk);
         want = '{32'(k), 32'd128, 32'(255 - k), (k == 0), (k == BLK-1)};
         n_checks++;
         if (out_valid !== 1'b1 || cur_obs() !== want) begin
            n_fail++; $display("FAIL stall_pixel k=%0d: got %h want %h", k, cur_obs(), want);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid_after: got %b want 0", out_valid); end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      int cnt = 0;
      trip_t e;
      do_reset();
      in_valid = 1'b1;
      for (int t = 0; t < 500; t++) begin
         in_data = 8'($urandom);
         @(negedge clk);
         if (in_ready !== 1'b1) break;
         model_accept(in_data);
         cnt++;
         @(posedge clk); #1;
      end
      n_checks++; if (cnt != 2*N) begin n_fail++; $display("FAIL bp_accept_count: got %0d want %0d", cnt, 2*N); end
      @(posedge clk); #1;
      repeat (3) begin
         @(negedge clk);
         n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_held: in_ready got %b want 0", in_ready); end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      for (int k = 0; k < BLK; k++) begin
         @(negedge clk);
         e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
         n_checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || cur_obs() !== exp_obs(e, k)) begin
            n_fail++; $display("FAIL bp_drain k=%0d: in_ready=%b valid=%b got %h want %h", k, in_ready, out_valid, cur_obs(), exp_obs(e, k));
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_return: got %b want 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic test_streaming();
      int d0, got = 0;
      bit s_ok = 1'b1;
      do_reset();
      d0 = n_done;
      fork
         begin
            bit o;
            for (int m = 0; m < 4 && s_ok; m++) begin
               for (int i = 0; i < N; i++) begin
                  push_sample((i < BLK) ? 8'(i + m) : (i < 2*BLK) ? 8'(m) : 8'(i - 2*BLK), 50, o);
                  if (!o) begin s_ok = 1'b0; break; end
               end
            end
         end
         begin
            obs_t o;
            bit ok;
            trip_t e;
            for (int j = 0; j < 4*BLK; j++) begin
               recv_one(50, o, ok);
               n_checks++;
               if (!ok) begin n_fail++; $display("FAIL stream_timeout: triplet %0d never arrived", j); break; end
               e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
               if (o !== exp_obs(e, j % BLK)) begin
                  n_fail++; $display("FAIL stream_pixel j=%0d: got %h want %h", j, o, exp_obs(e, j % BLK));
               end
               got++;
            end
         end
      join
      repeat (2) @(posedge clk); #1;
      n_checks++; if (!s_ok) begin n_fail++; $display("FAIL stream_send: sender timed out"); end
      n_checks++; if (got != 4*BLK) begin n_fail++; $display("FAIL stream_count: got %0d want %0d", got, 4*BLK); end
      n_checks++; if (n_done - d0 != 4) begin n_fail++; $display("FAIL stream_done_count: got %0d want 4", n_done - d0); end
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stream_leftover: got %0d want 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      obs_t o;
      trip_t e;
      do_reset();
      for (int i = 0; i < 100; i++) push_sample(8'($urandom), 100, ok);
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_during_reset: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
      @(posedge clk); #1 rst = 1'b0;
      model_reset();
      for (int i = 0; i < N; i++) mcu[i] = 8'(i);
      send_mcu(70, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rmid_send: timeout accepting samples"); end
      for (int k = 0; k < BLK; k++) begin
         recv_one(100, o, ok);
         e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
         n_checks++;
         if (!ok || o !== exp_obs(e, k)) begin
            n_fail++; $display("FAIL rmid_pixel k=%0d: ok=%b got %h want %h", k, ok, o, exp_obs(e, k));
         end
      end
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_residue: out_valid got %b want 0", out_valid); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_full();
      bit ok;
      obs_t o;
      trip_t e;
      do_reset();
      for (int i = 0; i < 2*N; i++) push_sample(8'($urandom), 100, ok);
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL rfull_both_full: in_ready=%b out_valid=%b want 0/1", in_ready, out_valid); end
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_first !== 1'b0) begin n_fail++; $display("FAIL rfull_after_reset: valid=%b in_ready=%b first=%b want 0/1/0", out_valid, in_ready, out_first); end
      @(posedge clk); #1 rst = 1'b0;
      model_reset();
      for (int i = 0; i < N; i++) mcu[i] = 8'($urandom);
      send_mcu(100, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rfull_send: timeout accepting samples"); end
      for (int k = 0; k < BLK; k++) begin
         recv_one(80, o, ok);
         e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
         n_checks++;
         if (!ok || o !== exp_obs(e, k)) begin
            n_fail++; $display("FAIL rfull_pixel k=%0d: ok=%b got %h want %h", k, ok, o, exp_obs(e, k));
         end
      end
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rfull_idle_after: valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_stall();
      test_backpressure();
      test_streaming();
      test_reset_mid();
      test_reset_full();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
